// File: rtl/mem_pp_writer.sv
// Ping-pong write sequencer: steers a valid/ready word stream into two WORDS-deep
// banks, flags each bank full once its closing write has committed, stalls until released.
module mem_pp_writer #(
    parameter int DATA_W  = 16,
    parameter int WORDS   = 4,
    parameter int ADDR1_W = 2,
    parameter int CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               wr_en,
    output logic               wr_addr0,
    output logic [ADDR1_W-1:0] wr_addr1,
    output logic [DATA_W-1:0]  wr_data,
    output logic [1:0]         bank_full,
    output logic [1:0]         bank_last,
    output logic [CNT_W-1:0]   bank_words0,
    output logic [CNT_W-1:0]   bank_words1,
    input  logic [1:0]         bank_release
);

    logic               cur_bank_q, cur_bank_d;
    logic [ADDR1_W-1:0] word_ptr_q, word_ptr_d;
    logic [1:0]         bank_busy_q, bank_busy_d;
    logic               wr_en_q, wr_en_d;
    logic               wr_addr0_q, wr_addr0_d;
    logic [ADDR1_W-1:0] wr_addr1_q, wr_addr1_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [1:0]         bank_full_q, bank_full_d;
    logic [1:0]         bank_last_q, bank_last_d;
    logic [CNT_W-1:0]   bank_words0_q, bank_words0_d;
    logic [CNT_W-1:0]   bank_words1_q, bank_words1_d;
    // Closing bank bookkeeping, held for the one cycle between the last write and its commit.
    logic               pend_valid_q, pend_valid_d;
    logic               pend_bank_q, pend_bank_d;
    logic [CNT_W-1:0]   pend_cnt_q, pend_cnt_d;
    logic               pend_last_q, pend_last_d;

    logic accept;
    logic closing;

    assign in_ready = !rst && !bank_busy_q[cur_bank_q];
    assign accept   = in_valid && in_ready;
    assign closing  = accept && ((word_ptr_q == ADDR1_W'(WORDS - 1)) || in_last);

    always_comb begin
        cur_bank_d    = cur_bank_q;
        word_ptr_d    = word_ptr_q;
        bank_busy_d   = bank_busy_q;
        wr_en_d       = accept;
        wr_addr0_d    = wr_addr0_q;
        wr_addr1_d    = wr_addr1_q;
        wr_data_d     = wr_data_q;
        bank_full_d   = bank_full_q;
        bank_last_d   = bank_last_q;
        bank_words0_d = bank_words0_q;
        bank_words1_d = bank_words1_q;
        pend_valid_d  = closing;
        pend_bank_d   = pend_bank_q;
        pend_cnt_d    = pend_cnt_q;
        pend_last_d   = pend_last_q;

        if (accept) begin
            wr_addr0_d = cur_bank_q;
            wr_addr1_d = word_ptr_q;
            wr_data_d  = in_data;
        end

        if (closing) begin
            bank_busy_d[cur_bank_q] = 1'b1;
            cur_bank_d  = ~cur_bank_q;
            word_ptr_d  = '0;
            pend_bank_d = cur_bank_q;
            pend_cnt_d  = CNT_W'(word_ptr_q) + CNT_W'(1);
            pend_last_d = in_last;
        end else if (accept) begin
            word_ptr_d = word_ptr_q + ADDR1_W'(1);
        end

        if (pend_valid_q) begin
            bank_full_d[pend_bank_q] = 1'b1;
            bank_last_d[pend_bank_q] = pend_last_q;
            if (pend_bank_q) bank_words1_d = pend_cnt_q;
            else             bank_words0_d = pend_cnt_q;
        end

        // A release only counts once the bank is visibly full; the closing window ignores it.
        for (int b = 0; b < 2; b++) begin
            if (bank_release[b] && bank_full_q[b]) begin
                bank_full_d[b] = 1'b0;
                bank_busy_d[b] = 1'b0;
                bank_last_d[b] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_bank_q    <= 1'b0;
            word_ptr_q    <= '0;
            bank_busy_q   <= '0;
            wr_en_q       <= 1'b0;
            wr_addr0_q    <= 1'b0;
            wr_addr1_q    <= '0;
            wr_data_q     <= '0;
            bank_full_q   <= '0;
            bank_last_q   <= '0;
            bank_words0_q <= '0;
            bank_words1_q <= '0;
            pend_valid_q  <= 1'b0;
            pend_bank_q   <= 1'b0;
            pend_cnt_q    <= '0;
            pend_last_q   <= 1'b0;
        end else begin
            cur_bank_q    <= cur_bank_d;
            word_ptr_q    <= word_ptr_d;
            bank_busy_q   <= bank_busy_d;
            wr_en_q       <= wr_en_d;
            wr_addr0_q    <= wr_addr0_d;
            wr_addr1_q    <= wr_addr1_d;
            wr_data_q     <= wr_data_d;
            bank_full_q   <= bank_full_d;
            bank_last_q   <= bank_last_d;
            bank_words0_q <= bank_words0_d;
            bank_words1_q <= bank_words1_d;
            pend_valid_q  <= pend_valid_d;
            pend_bank_q   <= pend_bank_d;
            pend_cnt_q    <= pend_cnt_d;
            pend_last_q   <= pend_last_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr0    = wr_addr0_q;
    assign wr_addr1    = wr_addr1_q;
    assign wr_data     = wr_data_q;
    assign bank_full   = bank_full_q;
    assign bank_last   = bank_last_q;
    assign bank_words0 = bank_words0_q;
    assign bank_words1 = bank_words1_q;

endmodule

// File: tb/tb_mem_pp_writer.sv
// Bench for mem_pp_writer: directed scenarios plus a random stream, each checked against
// a bank-level model (fill queue per bank, full/last/count flags, one-cycle close commit).
module tb_mem_pp_writer;

    localparam int WORDS = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        wr_en;
    logic        wr_addr0;
    logic [1:0]  wr_addr1;
    logic [15:0] wr_data;
    logic [1:0]  bank_full;
    logic [1:0]  bank_last;
    logic [2:0]  bank_words0;
    logic [2:0]  bank_words1;
    logic [1:0]  bank_release;

    mem_pp_writer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .wr_data(wr_data), .bank_full(bank_full), .bank_last(bank_last),
        .bank_words0(bank_words0), .bank_words1(bank_words1), .bank_release(bank_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // reference model: bank being filled, words already in it, per-bank flags, close awaiting commit
    logic        m_fill;
    int          m_cnt;
    logic [1:0]  m_full;
    logic [1:0]  m_last;
    logic [2:0]  m_words [2];
    logic        m_pend;
    logic        m_pend_bank;
    logic [2:0]  m_pend_cnt;
    logic        m_pend_last;

    logic        obs_ready, exp_ready, last_acc;
    logic        exp_wr_en, exp_a0;
    logic [1:0]  exp_a1;
    logic [15:0] exp_d;

    task automatic model_reset();
        m_fill = 1'b0; m_cnt = 0; m_full = 2'b00; m_last = 2'b00;
        m_words[0] = 3'd0; m_words[1] = 3'd0;
        m_pend = 1'b0; m_pend_bank = 1'b0; m_pend_cnt = 3'd0; m_pend_last = 1'b0;
        exp_wr_en = 1'b0; last_acc = 1'b0;
    endtask

    task automatic do_reset(input logic hold_valid);
        @(negedge clk);
        rst = 1'b1; in_valid = hold_valid; in_data = 16'hbeef; in_last = 1'b0; bank_release = 2'b00;
        #1 obs_ready = in_ready;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic l, input logic [1:0] rel);
        logic [1:0] full_before;
        @(negedge clk);
        in_valid = v; in_data = d; in_last = l; bank_release = rel;
        #1 obs_ready = in_ready;
        exp_ready = !(m_full[m_fill] || (m_pend && m_pend_bank == m_fill));
        @(posedge clk);
        last_acc = v && exp_ready;
        full_before = m_full;
        if (m_pend) begin
            m_full[m_pend_bank] = 1'b1;
            m_last[m_pend_bank] = m_pend_last;
            m_words[m_pend_bank] = m_pend_cnt;
            m_pend = 1'b0;
        end
        for (int b = 0; b < 2; b++)
            if (rel[b] && full_before[b]) begin
                m_full[b] = 1'b0;
                m_last[b] = 1'b0;
            end
        exp_wr_en = last_acc;
        if (last_acc) begin
            exp_a0 = m_fill; exp_a1 = m_cnt[1:0]; exp_d = d;
            m_cnt++;
            if (m_cnt == WORDS || l) begin
                m_pend = 1'b1; m_pend_bank = m_fill; m_pend_cnt = 3'(m_cnt); m_pend_last = l;
                m_fill = ~m_fill; m_cnt = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++;
        if (obs_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b exp 0", obs_ready);
        end
        checks++;
        if ({wr_en, wr_addr0, wr_addr1, wr_data, bank_full, bank_last, bank_words0, bank_words1} !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got wr_en=%b a0=%b a1=%0d d=%h full=%b last=%b w0=%0d w1=%0d exp all 0",
                     wr_en, wr_addr0, wr_addr1, wr_data, bank_full, bank_last, bank_words0, bank_words1);
        end
    endtask

    task automatic test_fill_one_bank();
        logic [15:0] w [4] = '{16'habcd, 16'h79ca, 16'h1358, 16'h976a};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) step(1'b1, w[i], 1'b0, 2'b00);
            else       step(1'b0, 16'h0, 1'b0, 2'b00);
            checks++;
            if (obs_ready !== exp_ready) begin errors++; $display("FAIL fill_ready cyc %0d got %b exp %b", i, obs_ready, exp_ready); end
            checks++;
            if (wr_en !== exp_wr_en) begin errors++; $display("FAIL fill_wr_en cyc %0d got %b exp %b", i, wr_en, exp_wr_en); end
            if (exp_wr_en) begin
                checks++;
                if ({wr_addr0, wr_addr1, wr_data} !== {exp_a0, exp_a1, exp_d}) begin
                    errors++; $display("FAIL fill_write cyc %0d got (%b,%0d,%h) exp (%b,%0d,%h)", i, wr_addr0, wr_addr1, wr_data, exp_a0, exp_a1, exp_d);
                end
            end
            checks++;
            if ({bank_full, bank_last, bank_words1, bank_words0} !== {m_full, m_last, m_words[1], m_words[0]}) begin
                errors++; $display("FAIL fill_flags cyc %0d got full=%b last=%b w1=%0d w0=%0d exp full=%b last=%b w1=%0d w0=%0d",
                                   i, bank_full, bank_last, bank_words1, bank_words0, m_full, m_last, m_words[1], m_words[0]);
            end
        end
        checks++;
        if ({bank_full, bank_last, bank_words0} !== {2'b01, 2'b00, 3'd4}) begin
            errors++; $display("FAIL fill_bank0_full got full=%b last=%b w0=%0d exp full=01 last=00 w0=4", bank_full, bank_last, bank_words0);
        end
    endtask

    // continues from test_fill_one_bank: bank 0 full, bank 1 next
    task automatic test_stall_release();
        for (int i = 0; i < 11; i++) begin
            if (i < 4)       step(1'b1, 16'h1000 + 16'(i), 1'b0, 2'b00);
            else if (i < 8)  step(1'b1, 16'h5a09, 1'b0, 2'b00);
            else if (i == 8) step(1'b1, 16'h5a09, 1'b0, 2'b01);
            else if (i == 9) step(1'b1, 16'h5a09, 1'b0, 2'b00);
            else             step(1'b0, 16'h0, 1'b0, 2'b00);
            checks++;
            if (obs_ready !== exp_ready) begin errors++; $display("FAIL stall_ready cyc %0d got %b exp %b", i, obs_ready, exp_ready); end
            checks++;
            if (wr_en !== exp_wr_en) begin errors++; $display("FAIL stall_wr_en cyc %0d got %b exp %b", i, wr_en, exp_wr_en); end
            if (exp_wr_en) begin
                checks++;
                if ({wr_addr0, wr_addr1, wr_data} !== {exp_a0, exp_a1, exp_d}) begin
                    errors++; $display("FAIL stall_write cyc %0d got (%b,%0d,%h) exp (%b,%0d,%h)", i, wr_addr0, wr_addr1, wr_data, exp_a0, exp_a1, exp_d);
                end
            end
            checks++;
            if ({bank_full, bank_last, bank_words1, bank_words0} !== {m_full, m_last, m_words[1], m_words[0]}) begin
                errors++; $display("FAIL stall_flags cyc %0d got full=%b last=%b w1=%0d w0=%0d exp full=%b last=%b w1=%0d w0=%0d",
                                   i, bank_full, bank_last, bank_words1, bank_words0, m_full, m_last, m_words[1], m_words[0]);
            end
            if (i == 6) begin
                checks++;
                if ({obs_ready, bank_full} !== 3'b011) begin errors++; $display("FAIL stall_held got ready=%b full=%b exp ready=0 full=11", obs_ready, bank_full); end
            end
            if (i == 9) begin
                checks++;
                if ({wr_en, wr_addr0, wr_addr1, wr_data} !== {1'b1, 1'b0, 2'd0, 16'h5a09}) begin
                    errors++; $display("FAIL stall_resume got (%b,%b,%0d,%h) exp (1,0,0,5a09)", wr_en, wr_addr0, wr_addr1, wr_data);
                end
            end
        end
    endtask

    task automatic test_in_last();
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 0)      step(1'b1, 16'h84ad, 1'b0, 2'b00);
            else if (i == 1) step(1'b1, 16'hd3f5, 1'b1, 2'b00);
            else if (i == 2) step(1'b1, 16'hf4a2, 1'b0, 2'b00);
            else             step(1'b0, 16'h0, 1'b0, 2'b00);
            checks++;
            if (wr_en !== exp_wr_en) begin errors++; $display("FAIL last_wr_en cyc %0d got %b exp %b", i, wr_en, exp_wr_en); end
            if (exp_wr_en) begin
                checks++;
                if ({wr_addr0, wr_addr1, wr_data} !== {exp_a0, exp_a1, exp_d}) begin
                    errors++; $display("FAIL last_write cyc %0d got (%b,%0d,%h) exp (%b,%0d,%h)", i, wr_addr0, wr_addr1, wr_data, exp_a0, exp_a1, exp_d);
                end
            end
            if (i == 2) begin
                checks++;
                if ({wr_addr0, wr_addr1, wr_data} !== {1'b1, 2'd0, 16'hf4a2}) begin
                    errors++; $display("FAIL last_next_bank got (%b,%0d,%h) exp (1,0,f4a2)", wr_addr0, wr_addr1, wr_data);
                end
                checks++;
                if ({bank_full[0], bank_last[0], bank_words0} !== {1'b1, 1'b1, 3'd2}) begin
                    errors++; $display("FAIL last_flags got full0=%b last0=%b w0=%0d exp 1 1 2", bank_full[0], bank_last[0], bank_words0);
                end
            end
        end
    endtask

    task automatic test_empty_release();
        do_reset(1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i == 0)     step(1'b0, 16'h0, 1'b0, 2'b10);
            else if (i < 5) step(1'b1, 16'h2200 + 16'(i), 1'b0, 2'b00);
            else if (i == 5) step(1'b0, 16'h0, 1'b0, 2'b01);
            else            step(1'b0, 16'h0, 1'b0, 2'b00);
            checks++;
            if (obs_ready !== exp_ready) begin errors++; $display("FAIL empty_ready cyc %0d got %b exp %b", i, obs_ready, exp_ready); end
            checks++;
            if ({bank_full, bank_last, bank_words1, bank_words0} !== {m_full, m_last, m_words[1], m_words[0]}) begin
                errors++; $display("FAIL empty_flags cyc %0d got full=%b last=%b w1=%0d w0=%0d exp full=%b last=%b w1=%0d w0=%0d",
                                   i, bank_full, bank_last, bank_words1, bank_words0, m_full, m_last, m_words[1], m_words[0]);
            end
        end
        checks++;
        if ({bank_full, bank_words0} !== {2'b01, 3'd4}) begin
            errors++; $display("FAIL empty_window_release got full=%b w0=%0d exp full=01 w0=4", bank_full, bank_words0);
        end
    endtask

    task automatic test_back_to_back_release();
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) begin
            if (i < 8)       step(1'b1, 16'h3300 + 16'(i), 1'b0, 2'b00);
            else if (i == 8) step(1'b1, 16'h7e57, 1'b0, 2'b00);
            else if (i == 9) step(1'b1, 16'h7e57, 1'b0, 2'b01);
            else if (i == 10) step(1'b1, 16'h7e57, 1'b0, 2'b10);
            else             step(1'b0, 16'h0, 1'b0, 2'b00);
            checks++;
            if (obs_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready cyc %0d got %b exp %b", i, obs_ready, exp_ready); end
            checks++;
            if (wr_en !== exp_wr_en) begin errors++; $display("FAIL b2b_wr_en cyc %0d got %b exp %b", i, wr_en, exp_wr_en); end
            checks++;
            if ({bank_full, bank_last, bank_words1, bank_words0} !== {m_full, m_last, m_words[1], m_words[0]}) begin
                errors++; $display("FAIL b2b_flags cyc %0d got full=%b last=%b w1=%0d w0=%0d exp full=%b last=%b w1=%0d w0=%0d",
                                   i, bank_full, bank_last, bank_words1, bank_words0, m_full, m_last, m_words[1], m_words[0]);
            end
            if (i == 9) begin
                checks++;
                if (bank_full !== 2'b10) begin errors++; $display("FAIL b2b_first_release got full=%b exp 10", bank_full); end
            end
            if (i == 10) begin
                checks++;
                if ({bank_full, wr_en, wr_addr0, wr_addr1, wr_data} !== {2'b00, 1'b1, 1'b0, 2'd0, 16'h7e57}) begin
                    errors++; $display("FAIL b2b_resume got full=%b wr=(%b,%b,%0d,%h) exp full=00 wr=(1,0,0,7e57)",
                                       bank_full, wr_en, wr_addr0, wr_addr1, wr_data);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 16'h4400 + 16'(i), 1'b0, 2'b00);
        do_reset(1'b1);
        checks++;
        if (obs_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", obs_ready); end
        checks++;
        if ({wr_en, wr_addr0, wr_addr1, wr_data, bank_full, bank_last, bank_words0, bank_words1} !== 32'h0) begin
            errors++;
            $display("FAIL midrst_outputs got wr_en=%b a0=%b a1=%0d d=%h full=%b last=%b w0=%0d w1=%0d exp all 0",
                     wr_en, wr_addr0, wr_addr1, wr_data, bank_full, bank_last, bank_words0, bank_words1);
        end
        step(1'b1, 16'h9abc, 1'b0, 2'b00);
        checks++;
        if ({wr_en, wr_addr0, wr_addr1, wr_data} !== {1'b1, 1'b0, 2'd0, 16'h9abc}) begin
            errors++; $display("FAIL midrst_first_write got (%b,%b,%0d,%h) exp (1,0,0,9abc)", wr_en, wr_addr0, wr_addr1, wr_data);
        end
    endtask

    task automatic test_random();
        logic        v, l;
        logic [15:0] d;
        logic [1:0]  rel;
        do_reset(1'b0);
        v = 1'b0; d = 16'h0; l = 1'b0;
        for (int i = 0; i < 400; i++) begin
            // upstream holds an unaccepted word; otherwise it draws a new one
            if (!(v && !last_acc)) begin
                v = ($urandom_range(0, 3) != 0);
                d = 16'($urandom);
                l = ($urandom_range(0, 5) == 0);
            end
            rel = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            step(v, d, l, rel);
            checks++;
            if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", i, obs_ready, exp_ready); end
            checks++;
            if (wr_en !== exp_wr_en) begin errors++; $display("FAIL rand_wr_en cyc %0d got %b exp %b", i, wr_en, exp_wr_en); end
            if (exp_wr_en) begin
                checks++;
                if ({wr_addr0, wr_addr1, wr_data} !== {exp_a0, exp_a1, exp_d}) begin
                    errors++; $display("FAIL rand_write cyc %0d got (%b,%0d,%h) exp (%b,%0d,%h)", i, wr_addr0, wr_addr1, wr_data, exp_a0, exp_a1, exp_d);
                end
            end
            checks++;
            if ({bank_full, bank_last, bank_words1, bank_words0} !== {m_full, m_last, m_words[1], m_words[0]}) begin
                errors++; $display("FAIL rand_flags cyc %0d got full=%b last=%b w1=%0d w0=%0d exp full=%b last=%b w1=%0d w0=%0d",
                                   i, bank_full, bank_last, bank_words1, bank_words0, m_full, m_last, m_words[1], m_words[0]);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; bank_release = 2'b00;
        model_reset();
        test_reset();
        test_fill_one_bank();
        test_stall_release();
        test_in_last();
        test_empty_release();
        test_back_to_back_release();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
